line_payload_serializer: RTL and testbench



---
 rtl/dsi_pkg.sv | 16 +
 rtl/dsi_crc16_byte.sv | 20 ++
 rtl/line_payload_serializer.sv | 130 +++++++++++++
 tb/tb_line_payload_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared DSI constants: line geometry, payload CRC parameters and the
// serializer state encoding.
package dsi_pkg;

    localparam int          FRAME_LENGTH = 8;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'h8408;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CKS_LO,
        CKS_HI
    } state_t;

endpackage

// File: rtl/dsi_crc16_byte.sv
// One-byte step of the reflected CRC-16 used by DSI payloads and headers.
// Data bits are consumed LSB first.
module dsi_crc16_byte
    import dsi_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] next_crc
);

    // NOTE: combinational logic uses blocking '=' so each loop pass sees the
    // previous pass; the first assignment also covers every path, so no latch.
    always_comb begin
        next_crc = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC_POLY) : (next_crc >> 1);
        end
    end

endmodule

// File: rtl/line_payload_serializer.sv
// Serializes one latched pixel line into a byte stream followed by its
// two-byte CRC, with valid/ready handshaking on the byte side.
module line_payload_serializer #(
    parameter int FRAME_LENGTH = dsi_pkg::FRAME_LENGTH,
    parameter int BYTES_MAX    = FRAME_LENGTH * 3
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic [FRAME_LENGTH*24-1:0] payload,
    input  logic [15:0]                WC,
    input  logic                       fifo_done,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic                       byte_last,
    output logic                       busy,
    output logic [15:0]                crc,
    output logic                       crc_valid,
    output logic                       err
);

    import dsi_pkg::*;

    state_t                     state;
    logic [FRAME_LENGTH*24-1:0] payload_q;
    logic [FRAME_LENGTH*24-1:0] shifted;
    logic [15:0]                wc_q;
    logic [15:0]                cnt;
    logic [15:0]                cnt_next;
    logic [15:0]                crc_q;
    logic [15:0]                next_crc;
    logic                       wc_legal;
    logic                       load;
    logic                       xfer;

    assign wc_legal = ({16'd0, WC} <= 32'(BYTES_MAX));
    assign load     = (state == IDLE) && fifo_done && wc_legal;
    assign xfer     = byte_valid && byte_ready;
    assign cnt_next = cnt + 16'd1;
    assign shifted  = payload_q >> {cnt_next, 3'b000};
    assign crc      = crc_q;

    // The CRC always advances over the byte currently presented on byte_out.
    dsi_crc16_byte u_crc (
        .crc_in    (crc_q),
        .data_byte (byte_out),
        .next_crc  (next_crc)
    );

    // NOTE: the line buffer is pure datapath and is only read after a load,
    // so it carries no reset; that keeps a wide register free of reset routing.
    always_ff @(posedge pclk) begin
        if (load) begin
            payload_q <= payload;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            busy       <= 1'b0;
            crc_valid  <= 1'b0;
            err        <= 1'b0;
            crc_q      <= CRC_INIT;
            cnt        <= 16'd0;
            wc_q       <= 16'd0;
        end else begin
            crc_valid <= 1'b0;
            // Any fifo_done not turned into a line start is an error.
            err       <= fifo_done && !load;

            case (state)
                IDLE: begin
                    if (load) begin
                        wc_q       <= WC;
                        cnt        <= 16'd0;
                        crc_q      <= CRC_INIT;
                        byte_valid <= 1'b1;
                        busy       <= 1'b1;
                        if (WC == 16'd0) begin
                            state    <= CKS_LO;
                            byte_out <= CRC_INIT[7:0];
                        end else begin
                            state    <= SEND;
                            byte_out <= payload[7:0];
                        end
                    end
                end

                SEND: begin
                    if (xfer) begin
                        crc_q <= next_crc;
                        cnt   <= cnt_next;
                        if (cnt_next == wc_q) begin
                            state    <= CKS_LO;
                            byte_out <= next_crc[7:0];
                        end else begin
                            byte_out <= shifted[7:0];
                        end
                    end
                end

                CKS_LO: begin
                    if (xfer) begin
                        state     <= CKS_HI;
                        byte_out  <= crc_q[15:8];
                        byte_last <= 1'b1;
                    end
                end

                CKS_HI: begin
                    if (xfer) begin
                        state      <= IDLE;
                        byte_out   <= 8'h00;
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        busy       <= 1'b0;
                        crc_valid  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_payload_serializer.sv
// Directed scenarios for line_payload_serializer: reset, normal lines, empty
// line, illegal WC, back-pressure, stray fifo_done and mid-line reset.
`timescale 1ns/1ps
module tb_line_payload_serializer;

    localparam int FL   = dsi_pkg::FRAME_LENGTH;
    localparam int BMAX = FL * 3;

    logic              pclk       = 1'b0;
    logic              rst_n      = 1'b0;
    logic [FL*24-1:0]  payload    = '0;
    logic [15:0]       WC         = 16'd0;
    logic              fifo_done  = 1'b0;
    logic              byte_ready = 1'b0;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_last;
    logic              busy;
    logic [15:0]       crc;
    logic              crc_valid;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  got[$];
    logic        got_last[$];
    logic [7:0]  exp[$];
    logic [15:0] exp_crc;
    logic [15:0] crc_cap;
    logic        busy_first;
    int          crc_seen, err_cnt, stall_bad, valid_cycles, first_valid, end_cyc;

    always #5 pclk = ~pclk;

    line_payload_serializer dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .payload    (payload),
        .WC         (WC),
        .fifo_done  (fifo_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .busy       (busy),
        .crc        (crc),
        .crc_valid  (crc_valid),
        .err        (err)
    );

    task automatic load_bytes(input int base, input int n);
        payload = '0;
        for (int j = 0; j < n; j++) payload[j*8 +: 8] = 8'(base + j);
    endtask

    // Expected stream: payload bytes, then CRC low, then CRC high (bitwise model).
    task automatic build_expected(input int n);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'hFFFF;
        exp.delete();
        for (int j = 0; j < n; j++) begin
            d = payload[j*8 +: 8];
            exp.push_back(d);
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        exp_crc = c;
        exp.push_back(c[7:0]);
        exp.push_back(c[15:8]);
    endtask

    task automatic start_line(input int wc);
        @(negedge pclk);
        WC        = 16'(wc);
        fifo_done = 1'b1;
    endtask

    // Records accepted bytes; mode 0 = always ready, mode 1 = ready 1,0,0 repeating.
    task automatic collect(input int mode, input int inject_at, input int stop_after);
        logic       hold;
        logic [7:0] hb;
        logic       hl;
        got.delete();
        got_last.delete();
        crc_seen = 0; err_cnt = 0; stall_bad = 0; valid_cycles = 0;
        first_valid = -1; end_cyc = -1; crc_cap = 16'h0; busy_first = 1'b0;
        hold = 1'b0; hb = 8'h00; hl = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge pclk);
            fifo_done = 1'b0;
            if (cyc == inject_at) begin
                fifo_done = 1'b1;
                payload   = ~payload;
                WC        = 16'd3;
            end
            if (err === 1'b1) err_cnt++;
            if (hold && (byte_valid !== 1'b1 || byte_out !== hb || byte_last !== hl)) stall_bad++;
            if (byte_valid === 1'b1) begin
                valid_cycles++;
                if (first_valid < 0) begin
                    first_valid = cyc;
                    busy_first  = busy;
                end
            end
            if (crc_valid === 1'b1) begin
                crc_seen++;
                crc_cap = crc;
                end_cyc = cyc;
                break;
            end
            byte_ready = (mode == 0) ? 1'b1 : ((cyc % 3 == 0) ? 1'b1 : 1'b0);
            if (byte_valid === 1'b1 && byte_ready) begin
                got.push_back(byte_out);
                got_last.push_back(byte_last);
                if (got.size() == stop_after) break;
            end
            hold = (byte_valid === 1'b1) && !byte_ready;
            hb   = byte_out;
            hl   = byte_last;
        end
    endtask

    function automatic int line_diff();
        int bad;
        bad = 0;
        if (got.size() != exp.size()) return 1000;
        foreach (exp[i]) begin
            if (got[i] !== exp[i]) bad++;
            if (got_last[i] !== ((i == exp.size() - 1) ? 1'b1 : 1'b0)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge pclk);
        checks++;
        if ({byte_out, byte_valid, byte_last, busy, crc_valid, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {byte_out, byte_valid, byte_last, busy, crc_valid, err});
        end
        checks++;
        if (crc !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_crc: got %h expected ffff", crc);
        end
    endtask

    // First fifo_done is sampled on the very first edge after reset release.
    task automatic test_basic();
        load_bytes(8'h31, 9);
        build_expected(9);
        @(negedge pclk);
        rst_n     = 1'b1;
        WC        = 16'd9;
        fifo_done = 1'b1;
        collect(0, -1, 0);
        checks++;
        if (first_valid !== 0) begin errors++; $display("FAIL basic_latency: got %0d expected 0", first_valid); end
        checks++;
        if (busy_first !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_first); end
        checks++;
        if (line_diff() !== 0) begin errors++; $display("FAIL basic_bytes: got %0d diffs (size %0d) expected 0", line_diff(), got.size()); end
        checks++;
        if (crc_cap !== 16'h6F91) begin errors++; $display("FAIL basic_crc: got %h expected 6f91", crc_cap); end
        checks++;
        if (valid_cycles !== 11 || end_cyc !== 11) begin
            errors++;
            $display("FAIL basic_valid_run: got %0d cycles end %0d expected 11/11", valid_cycles, end_cyc);
        end
        checks++;
        if (byte_valid !== 1'b0) begin errors++; $display("FAIL basic_gap: got %b expected 0", byte_valid); end
    endtask

    task automatic test_wc_zero();
        build_expected(0);
        start_line(0);
        collect(0, -1, 0);
        checks++;
        if (got.size() !== 2 || line_diff() !== 0) begin
            errors++;
            $display("FAIL wc0_bytes: got %0d bytes (%0d diffs) expected 2 x ff", got.size(), line_diff());
        end
        checks++;
        if (crc_seen !== 1 || crc_cap !== 16'hFFFF) begin
            errors++;
            $display("FAIL wc0_crc: got %h (pulses %0d) expected ffff", crc_cap, crc_seen);
        end
    endtask

    task automatic test_illegal_wc();
        int e, v, b;
        e = 0; v = 0; b = 0;
        start_line(BMAX + 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            fifo_done = 1'b0;
            if (err === 1'b1) e++;
            if (byte_valid !== 1'b0) v++;
            if (busy !== 1'b0) b++;
        end
        checks++;
        if (e !== 1) begin errors++; $display("FAIL illegal_err: got %0d pulses expected 1", e); end
        checks++;
        if (v !== 0 || b !== 0) begin errors++; $display("FAIL illegal_quiet: got valid %0d busy %0d expected 0/0", v, b); end
    endtask

    task automatic test_stall();
        load_bytes(8'h50, 6);
        build_expected(6);
        start_line(6);
        collect(1, -1, 0);
        checks++;
        if (got.size() !== 8 || line_diff() !== 0) begin
            errors++;
            $display("FAIL stall_bytes: got %0d bytes (%0d diffs) expected 8 in order", got.size(), line_diff());
        end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_bad); end
        checks++;
        if (crc_cap !== exp_crc) begin errors++; $display("FAIL stall_crc: got %h expected %h", crc_cap, exp_crc); end
    endtask

    task automatic test_mid_fifo_done();
        load_bytes(8'hC0, 6);
        build_expected(6);
        start_line(6);
        collect(0, 2, 0);
        checks++;
        if (err_cnt !== 1) begin errors++; $display("FAIL mid_err: got %0d pulses expected 1", err_cnt); end
        checks++;
        if (line_diff() !== 0) begin errors++; $display("FAIL mid_bytes: got %0d diffs expected 0", line_diff()); end
        checks++;
        if (crc_cap !== exp_crc) begin errors++; $display("FAIL mid_crc: got %h expected %h", crc_cap, exp_crc); end
    endtask

    // fifo_done on the CKS_HI transfer edge is dropped; a new line follows right after.
    task automatic test_back_to_back();
        int v;
        v = 0;
        load_bytes(8'h10, 6);
        build_expected(6);
        start_line(6);
        collect(0, 7, 0);
        checks++;
        if (err_cnt !== 1 || line_diff() !== 0) begin
            errors++;
            $display("FAIL b2b_drop: got %0d err pulses %0d diffs expected 1/0", err_cnt, line_diff());
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            fifo_done = 1'b0;
            if (byte_valid !== 1'b0) v++;
        end
        checks++;
        if (v !== 0) begin errors++; $display("FAIL b2b_no_line: got %0d valid cycles expected 0", v); end
        load_bytes(8'hE0, 5);
        build_expected(5);
        start_line(5);
        collect(0, -1, 0);
        checks++;
        if (line_diff() !== 0 || crc_cap !== exp_crc) begin
            errors++;
            $display("FAIL b2b_second: got %0d diffs crc %h expected 0 / %h", line_diff(), crc_cap, exp_crc);
        end
    endtask

    task automatic test_reset_mid_line();
        int v;
        v = 0;
        load_bytes(8'h61, 9);
        build_expected(9);
        start_line(9);
        collect(0, -1, 3);
        checks++;
        if (got.size() !== 3) begin errors++; $display("FAIL rst_pre_bytes: got %0d expected 3", got.size()); end
        @(posedge pclk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_out, byte_valid, byte_last, busy, crc_valid, err} !== 13'd0 || crc !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h crc %h expected 0 / ffff",
                     {byte_out, byte_valid, byte_last, busy, crc_valid, err}, crc);
        end
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (byte_valid !== 1'b0 || busy !== 1'b0) v++;
        end
        checks++;
        if (v !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0", v); end
        load_bytes(8'hA0, 9);
        build_expected(9);
        start_line(9);
        collect(0, -1, 0);
        checks++;
        if (line_diff() !== 0 || crc_cap !== exp_crc) begin
            errors++;
            $display("FAIL rst_new_line: got %0d diffs crc %h expected 0 / %h", line_diff(), crc_cap, exp_crc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wc_zero();
        test_illegal_wc();
        test_stall();
        test_mid_fifo_done();
        test_back_to_back();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
